register_file_block: RTL and testbench
======================================

Name: register_file_block

Overview:
- 8-entry x 8-bit general register file for the 8-bit MIPS pipeline.
- Sits at the consuming end of the write-back stage: accepts the write-back result (ans_wb) and serves two registered read operands (rs, rt) to the execute stage.
- Same-cycle write-back-to-read bypass, hardwired r0, stall-hold with in-place operand refresh.

Parameters:
- DATA_W, 8, register and data width in bits
- ADDR_W, 3, register address width (2**ADDR_W registers)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- ans_wb  input  DATA_W  write-back result from write-back stage
- wb_addr  input  ADDR_W  destination register of write-back
- wb_en  input  1  write-back valid
- rs_addr  input  ADDR_W  source register A address
- rt_addr  input  ADDR_W  source register B address
- stall  input  1  pipeline stall; holds read outputs
- rs_data  output  DATA_W  registered operand A
- rt_data  output  DATA_W  registered operand B

Behaviour:
- reset low (asynchronous, any time): all 8 registers, rs_data, rt_data, and internal latched addresses cleared to 0 immediately; held while low. First write is accepted on the first rising edge with reset high.
- Write: on rising edge, if wb_en=1 and wb_addr!=0, regs[wb_addr] <= ans_wb. Writes to r0 are ignored; r0 always reads 0.
- Read, stall=0: on rising edge:
  - rs_data <= value(rs_addr); rt_data <= value(rt_addr).
  - Latched addresses <= rs_addr / rt_addr.
  - Latency: one clock from address to output.
- value(a):
  - 0 if a=0;
  - else ans_wb if wb_en=1 and wb_addr=a (same-edge bypass: the new value is returned, never the stale one);
  - else regs[a].
- Read, stall=1:
  - Addresses are ignored; latched addresses are unchanged.
  - rs_data/rt_data hold, except when wb_en=1, wb_addr!=0 and wb_addr equals a latched address. In that case the matching output(s) load ans_wb on that edge, so the stalled operand stays coherent.
  - Writes proceed normally during stall.
- rs_addr=rt_addr: both outputs carry the identical value, including the bypass case.
- wb_addr matching both latched addresses under stall: both outputs update.
- No X propagation: outputs are always driven from reset values or registered data.
- Purely synchronous datapath apart from reset; no combinational input-to-output path.

Test Plan:
- Reset: drive reset=0 mid-cycle after prior writes -> rs_data=rt_data=8'h00 immediately. After release, reading r1..r7 returns 8'h00.
- Write/read latency: write r3=8'hFF (wb_en=1) on edge N; rs_addr=3 on edge N+1 -> rs_data=8'hFF after edge N+1. r0 write of 8'h0F -> r0 still reads 8'h00.
- Bypass: same edge wb_en=1, wb_addr=5, ans_wb=8'h0F, rs_addr=5, rt_addr=5 -> after that edge rs_data=rt_data=8'h0F. Previous r5 content (8'hAA) is never output.
- Stall hold:
  - Setup: latch rs=r2 (8'h11), rt=r4 (8'h22), then stall=1 and change addresses to r6/r7.
  - Required: outputs stay 8'h11/8'h22 for 3 cycles.
  - Then write r4=8'h33 during stall -> rt_data=8'h33 next edge, rs_data stays 8'h11.
- Stall release: deassert stall with rs_addr=6 (8'h44) -> rs_data=8'h44 one edge later.
- Reset mid-operation: assert reset during a stalled bypass cycle -> all outputs and registers read 8'h00. Latched addresses cleared, so a subsequent r0 write under stall causes no update.

Source files
------------

// File: rtl/register_file_block.sv
// 8x8 register file for the 8-bit MIPS pipeline. The operands are registered, so data appears one clock after the address, with a same-edge write-back bypass.
// While stall is high the outputs hold, except that an output whose latched address is being written reloads with the new value.
module register_file_block #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ans_wb,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              stall,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [ADDR_W-1:0] rs_lat;
  logic [ADDR_W-1:0] rt_lat;
  logic              wr_hit;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  assign wr_hit = wb_en && (wb_addr != '0);

  // The write-back value takes priority over the stored copy so a same-edge read never sees stale data.
  always_comb begin
    rs_val = regs[rs_addr];
    if (rs_addr == '0)
      rs_val = '0;
    else if (wr_hit && (wb_addr == rs_addr))
      rs_val = ans_wb;
  end

  always_comb begin
    rt_val = regs[rt_addr];
    if (rt_addr == '0)
      rt_val = '0;
    else if (wr_hit && (wb_addr == rt_addr))
      rt_val = ans_wb;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wr_hit) begin
      regs[wb_addr] <= ans_wb;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_data <= '0;
      rt_data <= '0;
      rs_lat  <= '0;
      rt_lat  <= '0;
    end else if (!stall) begin
      rs_data <= rs_val;
      rt_data <= rt_val;
      rs_lat  <= rs_addr;
      rt_lat  <= rt_addr;
    end else begin
      // Under stall, refresh an operand whose register is being written so it stays coherent.
      if (wr_hit && (wb_addr == rs_lat))
        rs_data <= ans_wb;
      if (wr_hit && (wb_addr == rt_lat))
        rt_data <= ans_wb;
    end
  end

endmodule

// File: tb/tb_register_file_block.sv
// Directed bench for register_file_block; expected values are hand-computed constants.
module tb_register_file_block;

  logic       clk;
  logic       reset;
  logic [7:0] ans_wb;
  logic [2:0] wb_addr;
  logic       wb_en;
  logic [2:0] rs_addr;
  logic [2:0] rt_addr;
  logic       stall;
  logic [7:0] rs_data;
  logic [7:0] rt_data;

  int total;
  int fails;

  register_file_block #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .ans_wb  (ans_wb),
    .wb_addr (wb_addr),
    .wb_en   (wb_en),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .stall   (stall),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [2:0] wa, input logic [7:0] d,
                       input logic [2:0] ra, input logic [2:0] rb, input logic st);
    wb_en   = en;
    wb_addr = wa;
    ans_wb  = d;
    rs_addr = ra;
    rt_addr = rb;
    stall   = st;
  endtask

  initial begin
    total = 0;
    fails = 0;
    reset = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
    #1;
    check("reset_rs", rs_data, 8'h00);
    check("reset_rt", rt_data, 8'h00);
    #11;
    reset = 1'b1;

    // write r3 = FF, read it on the following edge
    drive(1'b1, 3'd3, 8'hFF, 3'd0, 3'd0, 1'b0);
    step();
    check("r0_read_rs", rs_data, 8'h00);
    drive(1'b1, 3'd0, 8'h0F, 3'd3, 3'd0, 1'b0);
    step();
    check("r3_latency", rs_data, 8'hFF);
    check("r0_write_bypass", rt_data, 8'h00);
    drive(1'b0, 3'd0, 8'h00, 3'd3, 3'd0, 1'b0);
    step();
    check("r0_after_write", rt_data, 8'h00);

    // bypass: r5 holds AA, same-edge write of 0F must win
    drive(1'b1, 3'd5, 8'hAA, 3'd0, 3'd0, 1'b0);
    step();
    drive(1'b1, 3'd5, 8'h0F, 3'd5, 3'd5, 1'b0);
    step();
    check("bypass_rs", rs_data, 8'h0F);
    check("bypass_rt", rt_data, 8'h0F);
    drive(1'b0, 3'd0, 8'h00, 3'd5, 3'd3, 1'b0);
    step();
    check("r5_stored", rs_data, 8'h0F);

    // stall hold setup
    drive(1'b1, 3'd2, 8'h11, 3'd0, 3'd0, 1'b0); step();
    drive(1'b1, 3'd4, 8'h22, 3'd0, 3'd0, 1'b0); step();
    drive(1'b1, 3'd6, 8'h44, 3'd0, 3'd0, 1'b0); step();
    drive(1'b1, 3'd7, 8'h55, 3'd0, 3'd0, 1'b0); step();
    drive(1'b0, 3'd0, 8'h00, 3'd2, 3'd4, 1'b0); step();
    check("latch_rs", rs_data, 8'h11);
    check("latch_rt", rt_data, 8'h22);
    drive(1'b0, 3'd0, 8'h00, 3'd6, 3'd7, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_hold_rs%0d", i), rs_data, 8'h11);
      check($sformatf("stall_hold_rt%0d", i), rt_data, 8'h22);
    end
    drive(1'b1, 3'd6, 8'h66, 3'd6, 3'd7, 1'b1);
    step();
    check("stall_other_wr_rs", rs_data, 8'h11);
    check("stall_other_wr_rt", rt_data, 8'h22);
    drive(1'b1, 3'd4, 8'h33, 3'd6, 3'd7, 1'b1);
    step();
    check("stall_refresh_rt", rt_data, 8'h33);
    check("stall_refresh_rs", rs_data, 8'h11);

    // release stall: r6 now 66, r4 now 33
    drive(1'b0, 3'd0, 8'h00, 3'd6, 3'd4, 1'b0);
    step();
    check("release_rs", rs_data, 8'h66);
    check("release_rt", rt_data, 8'h33);

    // both latched addresses match under stall
    drive(1'b0, 3'd0, 8'h00, 3'd4, 3'd4, 1'b0); step();
    check("same_addr_rs", rs_data, 8'h33);
    check("same_addr_rt", rt_data, 8'h33);
    drive(1'b1, 3'd4, 8'h77, 3'd1, 3'd1, 1'b1); step();
    check("stall_both_rs", rs_data, 8'h77);
    check("stall_both_rt", rt_data, 8'h77);

    // async reset during a stalled bypass cycle
    drive(1'b1, 3'd4, 8'h99, 3'd4, 3'd4, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_rs", rs_data, 8'h00);
    check("async_rst_rt", rt_data, 8'h00);
    step();
    check("rst_held_rs", rs_data, 8'h00);
    check("rst_held_rt", rt_data, 8'h00);
    reset = 1'b1;
    drive(1'b1, 3'd0, 8'h0F, 3'd4, 3'd4, 1'b1);
    step();
    check("post_rst_r0_rs", rs_data, 8'h00);
    check("post_rst_r0_rt", rt_data, 8'h00);
    drive(1'b1, 3'd4, 8'h5A, 3'd4, 3'd4, 1'b1);
    step();
    check("lat_cleared_rs", rs_data, 8'h00);
    check("lat_cleared_rt", rt_data, 8'h00);

    // registers cleared by reset; only r4 rewritten afterwards
    for (int i = 1; i < 8; i++) begin
      drive(1'b0, 3'd0, 8'h00, 3'(i), 3'(i), 1'b0);
      step();
      check($sformatf("post_rst_r%0d", i), rs_data, (i == 4) ? 8'h5A : 8'h00);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
